// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - decodes a scanned 4-digit FND an/seg bus back to BCD and binary (optional FND_DP_CAPTURE_EN)
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 400_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an_in,
  input  logic [7:0]  seg_in,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic        frame_done,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic        anim_detect,
  output logic [3:0]  dp
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FRAME_TIMEOUT - 1);

`ifdef FND_DP_CAPTURE_EN
  localparam int SEGW = 8;
`else
  // The decimal point plays no part in settling or decoding in this build.
  localparam int SEGW = 7;
  logic unused_seg_dp;
  assign unused_seg_dp = seg_in[7];
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t state, state_next;

  logic [3:0]      an_s1, an_s2, an_p;
  logic [SEGW-1:0] seg_s1, seg_s2, seg_p;
  logic [CW-1:0]   settle_cnt;
  logic [TW-1:0]   timeout_cnt;
  logic [3:0]      mask;
  logic            anim_seen;

  logic            changed, an_ok;
  logic            cnt_clr, cnt_inc, capture;
  logic [3:0]      cap_pos;
  logic [3:0]      dec;
  logic            dec_err, single_seg;
  logic            frame_pend, completing, timeout_hit;
  logic [13:0]     frame_value;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = 4'd0;
      7'h79:   seg_decode = 4'd1;
      7'h24:   seg_decode = 4'd2;
      7'h30:   seg_decode = 4'd3;
      7'h19:   seg_decode = 4'd4;
      7'h12:   seg_decode = 4'd5;
      7'h02:   seg_decode = 4'd6;
      7'h78:   seg_decode = 4'd7;
      7'h00:   seg_decode = 4'd8;
      7'h10:   seg_decode = 4'd9;
      default: seg_decode = 4'hF;
    endcase
  endfunction

  // Two-flop synchronizer plus a one-cycle-old copy used for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      an_p   <= 4'hF;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
    end else begin
      an_s1  <= an_in;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= seg_in[SEGW-1:0];
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  assign changed = (an_s2 != an_p) || (seg_s2 != seg_p);
  assign an_ok   = ($countones(~an_s2) == 1);

  // Scan FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a digit is captured once an/seg have held still long enough.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (an_ok) begin
          state_next = SETTLE;
          cnt_clr    = 1'b1;
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_clr    = 1'b1;
          state_next = an_ok ? SETTLE : IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next = CAPTURE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        if (changed) begin
          cnt_clr    = 1'b1;
          state_next = an_ok ? SETTLE : IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (changed) begin
          cnt_clr    = 1'b1;
          state_next = an_ok ? SETTLE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Settle counter, restarted on every an/seg change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        settle_cnt <= '0;
    else if (cnt_clr) settle_cnt <= '0;
    else if (cnt_inc) settle_cnt <= settle_cnt + CW'(1);
  end

  // The previous-cycle copy is the settled one, even if the bus moves during CAPTURE.
  assign cap_pos     = capture ? ~an_p : 4'b0000;
  assign dec         = seg_decode(seg_p[6:0]);
  assign dec_err     = (dec == 4'hF);
  assign single_seg  = ($countones(~seg_p[6:0]) == 1);
  assign frame_pend  = (mask == 4'hF);
  assign completing  = capture && ((mask | cap_pos) == 4'hF);
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST) && !completing && !frame_pend;

  assign frame_value = 14'(digits[15:12]) * 14'd1000 + 14'(digits[11:8]) * 14'd100
                     + 14'(digits[7:4]) * 14'd10 + 14'(digits[3:0]);

  // Digit slots, frame completion, timeout and animation tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= 16'hFFFF;
      value       <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      digit_err   <= 4'b0000;
      anim_detect <= 1'b0;
      anim_seen   <= 1'b0;
      mask        <= 4'b0000;
      timeout_cnt <= '0;
    end else begin
      frame_done <= frame_pend;
      for (int i = 0; i < 4; i++) begin
        if (cap_pos[i]) begin
          digits[i*4 +: 4] <= dec;
          digit_err[i]     <= dec_err;
        end
      end
      if (frame_pend) begin
        mask        <= cap_pos;
        timeout_cnt <= '0;
        frame_valid <= (digit_err == 4'b0000);
        if (digit_err == 4'b0000) value <= frame_value;
        anim_seen   <= 1'b0;
        anim_detect <= 1'b0;
      end else if (timeout_hit) begin
        mask        <= 4'b0000;
        timeout_cnt <= '0;
        frame_valid <= 1'b0;
        anim_detect <= anim_seen;
        anim_seen   <= 1'b0;
      end else begin
        mask        <= mask | cap_pos;
        timeout_cnt <= timeout_cnt + TW'(1);
      end
      if (capture && single_seg) anim_seen <= 1'b1;
    end
  end

`ifdef FND_DP_CAPTURE_EN
  // Decimal points follow every capture of their digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap_pos[i]) dp[i] <= ~seg_p[7];
      end
    end
  end
`else
  assign dp = 4'b0000;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb/tb_fnd_scan_decoder.sv - scoreboard bench for fnd_scan_decoder
module tb_fnd_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an_in = 4'hF;
  logic [7:0]  seg_in = 8'hFF;
  logic [15:0] digits;
  logic [13:0] value;
  logic        frame_done, frame_valid, anim_detect;
  logic [3:0]  digit_err, dp;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] digits;
    logic [13:0] value;
    logic        valid;
    logic [3:0]  err;
    logic        anim;
    logic [3:0]  dp;
  } exp_t;

  exp_t exp_q[$];

`ifdef FND_DP_CAPTURE_EN
  localparam logic [3:0] DP_HUND = 4'b0100;
`else
  localparam logic [3:0] DP_HUND = 4'b0000;
`endif

  fnd_scan_decoder #(.SETTLE_CYCLES(4), .FRAME_TIMEOUT(200)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .seg_in(seg_in),
    .digits(digits), .value(value), .frame_done(frame_done),
    .frame_valid(frame_valid), .digit_err(digit_err),
    .anim_detect(anim_detect), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: seg7 = 7'h40;  1: seg7 = 7'h79;  2: seg7 = 7'h24;  3: seg7 = 7'h30;
      4: seg7 = 7'h19;  5: seg7 = 7'h12;  6: seg7 = 7'h02;  7: seg7 = 7'h78;
      8: seg7 = 7'h00;  9: seg7 = 7'h10;  default: seg7 = 7'h7F;
    endcase
  endfunction

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input int v, input logic ok,
                      input logic [3:0] e, input logic [3:0] p);
    exp_t x;
    x.digits = d; x.value = 14'(v); x.valid = ok; x.err = e; x.anim = 1'b0; x.dp = p;
    exp_q.push_back(x);
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0);
    drive(4'b1110, {1'b1, seg7(d0)}, 20);
    drive(4'b1101, {1'b1, seg7(d1)}, 20);
    drive(4'b1011, {1'b1, seg7(d2)}, 20);
    drive(4'b0111, {1'b1, seg7(d3)}, 20);
  endtask

  // Monitor: each frame_done pulse is matched against the next queued frame.
  always @(negedge clk) begin
    if (!reset && frame_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame_done got=1 expected=0 value=%0d", value);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_digits", 32'(digits), 32'(e.digits));
        chk("frame_value", 32'(value), 32'(e.value));
        chk("frame_valid", 32'(frame_valid), 32'(e.valid));
        chk("frame_digit_err", 32'(digit_err), 32'(e.err));
        chk("frame_anim", 32'(anim_detect), 32'(e.anim));
        chk("frame_dp", 32'(dp), 32'(e.dp));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_digits", 32'(digits), 32'hFFFF);
    chk("reset_value", 32'(value), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    chk("reset_frame_valid", 32'(frame_valid), 0);
    chk("reset_digit_err", 32'(digit_err), 0);
    chk("reset_anim", 32'(anim_detect), 0);
    chk("reset_dp", 32'(dp), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    push(16'h1234, 1234, 1'b1, 4'b0000, 4'b0000);
    scan(1, 2, 3, 4);
    push(16'h0000, 0, 1'b1, 4'b0000, 4'b0000);
    scan(0, 0, 0, 0);
    push(16'h9999, 9999, 1'b1, 4'b0000, 4'b0000);
    scan(9, 9, 9, 9);

    // Blank tens digit: invalid frame, value keeps 9999.
    push(16'h43F1, 9999, 1'b0, 4'b0010, 4'b0000);
    drive(4'b1110, {1'b1, seg7(1)}, 20);
    drive(4'b1101, 8'hFF, 20);
    drive(4'b1011, {1'b1, seg7(3)}, 20);
    drive(4'b0111, {1'b1, seg7(4)}, 20);

    // Anode glitch mid-tens and a 3-clock ones dwell that must not be captured.
    push(16'h2468, 2468, 1'b1, 4'b0000, 4'b0000);
    drive(4'b1110, {1'b1, seg7(8)}, 20);
    drive(4'b1101, {1'b1, seg7(6)}, 10);
    drive(4'b1100, {1'b1, seg7(6)}, 2);
    drive(4'b1101, {1'b1, seg7(6)}, 10);
    drive(4'b1011, {1'b1, seg7(4)}, 20);
    drive(4'b1110, {1'b1, seg7(9)}, 3);
    drive(4'b0111, {1'b1, seg7(2)}, 20);

    // Chase animation on the ones anode until the frame timeout expires.
    for (int i = 0; i < 30; i++) begin
      case (i % 6)
        0: drive(4'b1110, 8'hDF, 8);
        1: drive(4'b1110, 8'hFE, 8);
        2: drive(4'b1110, 8'hFD, 8);
        3: drive(4'b1110, 8'hFB, 8);
        4: drive(4'b1110, 8'hF7, 8);
        default: drive(4'b1110, 8'hEF, 8);
      endcase
    end
    @(negedge clk);
    chk("chase_frame_valid", 32'(frame_valid), 0);
    chk("chase_anim_detect", 32'(anim_detect), 1);
    chk("chase_value_held", 32'(value), 2468);
    chk("chase_ones_err", 32'(digit_err[0]), 1);
    @(posedge clk);
    #1;

    push(16'h5678, 5678, 1'b1, 4'b0000, 4'b0000);
    scan(5, 6, 7, 8);

    // Decimal point lit on the hundreds digit only.
    push(16'h1357, 1357, 1'b1, 4'b0000, DP_HUND);
    drive(4'b1110, {1'b1, seg7(7)}, 20);
    drive(4'b1101, {1'b1, seg7(5)}, 20);
    drive(4'b1011, {1'b0, seg7(3)}, 20);
    drive(4'b0111, {1'b1, seg7(1)}, 20);

    drive(4'b1111, 8'hFF, 10);
    chk("frames_outstanding", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fnd_scan_decoder.md
Name: fnd_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit FND scan driver.
- Samples the multiplexed active-low anode/segment bus (an/seg), decodes each scanned digit back to BCD and reassembles the displayed 0..9999 value.
- Flags invalid frames and the single-segment chase animation.
- Used as an in-system display monitor and as the bench-side checker for every display path.

Parameters:
- SETTLE_CYCLES, 16: clocks an/seg must be stable (same one-hot anode, same seg) before a digit is captured.
- FRAME_TIMEOUT, 400_000: clocks without frame completion before frame state is invalidated.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- an_in  in  4  anode bus, active low; bit0 = ones digit, bit3 = thousands digit
- seg_in  in  8  segment bus, active low; bit7 = dp, bits6:0 = g..a
- digits  out  16  latched BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands; 4'hF = undecodable
- value  out  14  binary value of last valid frame
- frame_done  out  1  one-cycle pulse on frame completion
- frame_valid  out  1  last completed frame had four decodable digits
- digit_err  out  4  per-digit undecodable flag from last capture of that digit
- anim_detect  out  1  chase animation detected
- dp  out  4  captured decimal points (see Optional Feature)

Behaviour:
- Reset: digits = 16'hFFFF, value = 0, frame_done = 0, frame_valid = 0, digit_err = 0, anim_detect = 0, dp = 0. Internal capture mask = 0, counters = 0, FSM = IDLE.
- Inputs pass through a 2-flop synchronizer; all timing below counts from the synchronized copies.
- Anode is valid only when exactly one bit of an_in is 0. 4'b1111 or multiple zeros are invalid.
- FSM states:
  - IDLE: anode invalid. Go to SETTLE when the anode becomes valid; settle counter = 0.
  - SETTLE: counter increments while an/seg are unchanged from the previous cycle.
    - Any change restarts the counter (new anode → stay in SETTLE; invalid anode → IDLE).
    - When counter == SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE (1 cycle):
    - Decode seg_in[6:0]: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
    - Any other pattern gives digit F and sets digit_err for that position.
    - Write the digit slot, set that mask bit, then go to HOLD.
  - HOLD: wait. An an/seg change goes to SETTLE or IDLE; no recapture while unchanged.
- Recapturing a digit before frame completion overwrites its slot; the mask bit stays set.
- Single-segment capture: seg_in[6:0] with exactly one 0 bit sets internal anim_seen.
- Frame completion:
  - Cycle after mask reaches 4'b1111: frame_done = 1 for exactly 1 cycle; mask cleared; timeout counter cleared; anim_seen cleared; anim_detect = 0.
  - frame_valid = (digit_err == 0).
  - If valid, value = d1000*1000 + d100*100 + d10*10 + d1 (14-bit, max 9999), updated in the same cycle as frame_done. If invalid, value holds its previous content.
- Timeout:
  - Counter increments every cycle and clears on frame_done.
  - On reaching FRAME_TIMEOUT-1: frame_valid = 0, mask = 0, counter = 0, anim_detect = anim_seen, anim_seen = 0.
  - digits and value hold their previous content.
- Simultaneous events: a capture completing the mask in the same cycle as the timeout takes priority; the frame completes and the timeout is ignored.
- Reset asserted mid-operation returns everything to reset values immediately.

Optional Feature:
- FND_DP_CAPTURE_EN defined: CAPTURE also stores ~seg_in[7] into dp[position]; dp updates with every capture.
- Not defined: dp is constant 0 and seg_in[7] is ignored entirely.

Test Plan:
- Scan value 1234 (SETTLE_CYCLES=4, 20 clocks per digit, ones first, seg 19/30/24/79 per position): frame_done pulses once per scan; value = 1234; digits = 16'h1234; frame_valid = 1.
- Scan 0000 then 9999 in consecutive frames: value goes 0 → 9999; frame_valid = 1 both frames.
- Anode glitch 4'b1100 for 2 clocks mid-digit, plus a 3-clock dwell with SETTLE_CYCLES=4: no capture occurs; frame completes only after the full four-digit scan.
- Tens digit shows seg 7F (blank): frame_done with frame_valid = 0, digit_err = 4'b0010, digits[7:4] = F, value unchanged.
- Chase animation (one anode at a time, seg 5F/7E/7D..., FRAME_TIMEOUT=200): no frame_done; after 200 clocks frame_valid = 0 and anim_detect = 1. A subsequent valid 5678 scan gives anim_detect = 0 and value = 5678.
- FND_DP_CAPTURE_EN with seg_in[7] = 0 on the hundreds digit: dp = 4'b0100. Without the macro: dp = 0.
